// File: rtl/watch_pkg.sv
// Shared types and constants for the watch edit control unit.
package watch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EDIT   = 2'd1,
        ST_DELAY  = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    // Field indices, least significant first
    localparam int F_MSEC = 0;
    localparam int F_SEC  = 1;
    localparam int F_MIN  = 2;
    localparam int F_HOUR = 3;

    // Default geometry and timing (timing in 1 kHz ticks)
    localparam int DEF_NUM_FIELDS   = 4;
    localparam int DEF_PAGE_SIZE    = 2;
    localparam int DEF_REPEAT_DELAY = 500;
    localparam int DEF_REPEAT_RATE  = 100;
    localparam int DEF_IDLE_TIMEOUT = 10000;
    localparam int DEF_BLINK_HALF   = 250;

    // Bit positions of the buttons in the packed {C,U,D,L,R} vector
    localparam int BTN_NUM = 5;
    localparam int BTN_R   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_D   = 2;
    localparam int BTN_U   = 3;
    localparam int BTN_C   = 4;

    localparam logic [BTN_NUM-1:0] MASK_U = BTN_NUM'(1) << BTN_U;
    localparam logic [BTN_NUM-1:0] MASK_D = BTN_NUM'(1) << BTN_D;

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a vector of debounced button levels.
// The previous-level registers reset to 1 so a button held through reset
// is not mistaken for a fresh press.
module btn_edge #(
    parameter int W = 5
)(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] level_q
);

    // Capture the level and flag a low-to-high transition one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '1;
            rise    <= '0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/watch_edit_cu.sv
// Watch control unit: field selection by page, edit mode with inc/dec
// pulses, hold-to-repeat, idle timeout and blink of the selected field.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | normal display; L/R move within the current page
//   ST_EDIT   | editing; L/R wrap over all fields, U/D emit one pulse
//   ST_DELAY  | U/D held, waiting REPEAT_DELAY ticks before auto-repeat
//   ST_REPEAT | U/D still held, one pulse every REPEAT_RATE ticks
module watch_edit_cu
    import watch_pkg::*;
#(
    parameter int NUM_FIELDS   = DEF_NUM_FIELDS,
    parameter int PAGE_SIZE    = DEF_PAGE_SIZE,
    parameter int SEL_W        = 2,
    parameter int PAGE_W       = 1,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int BLINK_HALF   = DEF_BLINK_HALF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_btnL,
    input  logic              i_btnR,
    input  logic              i_btnU,
    input  logic              i_btnD,
    input  logic              i_btnC,
    input  logic [PAGE_W-1:0] i_page,
    output logic [SEL_W-1:0]  o_field_sel,
    output logic              o_edit_mode,
    output logic              o_inc,
    output logic              o_dec,
    output logic              o_blink
);

    localparam int NUM_PAGES = NUM_FIELDS / PAGE_SIZE;
    localparam int HOLD_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W    = $clog2(HOLD_MAX) + 1;
    localparam int IDLE_W    = $clog2(IDLE_TIMEOUT) + 1;
    localparam int BLINK_W   = $clog2(BLINK_HALF) + 1;

    logic [BTN_NUM-1:0] lvl, rise, lvl_q;

    state_t             state, state_n;
    logic [SEL_W-1:0]   field_sel, field_n;
    logic [PAGE_W-1:0]  page_q, page_n;
    logic               inc, inc_n, dec, dec_n;
    logic               blink, blink_n;
    logic               dir_up, dir_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_n;
    logic [IDLE_W-1:0]  idle_cnt, idle_n;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;

    int                 page_int;
    logic [PAGE_W-1:0]  eff_page;
    logic [SEL_W-1:0]   page_base, page_top;
    logic               held, go_run, pulse;

    assign lvl = {i_btnC, i_btnU, i_btnD, i_btnL, i_btnR};

    btn_edge #(.W(BTN_NUM)) u_btn_edge (
        .clk     (clk),
        .rst     (rst),
        .level   (lvl),
        .rise    (rise),
        .level_q (lvl_q)
    );

    // Clamp the page switch to the last real page and derive its field range
    always_comb begin
        page_int = int'(i_page);
        if (page_int > NUM_PAGES - 1) page_int = NUM_PAGES - 1;
        eff_page  = PAGE_W'(page_int);
        page_base = SEL_W'(page_int * PAGE_SIZE);
        page_top  = SEL_W'(page_int * PAGE_SIZE + PAGE_SIZE - 1);
    end

    // The latched direction button, as seen through the edge detector delay
    assign held = |(lvl_q & (dir_up ? MASK_U : MASK_D));

    // Next-state, counters and registered outputs
    always_comb begin
        state_n     = state;
        field_n     = field_sel;
        page_n      = page_q;
        inc_n       = 1'b0;
        dec_n       = 1'b0;
        blink_n     = blink;
        dir_n       = dir_up;
        hold_n      = hold_cnt;
        idle_n      = idle_cnt;
        blink_cnt_n = blink_cnt;
        go_run      = 1'b0;
        pulse       = 1'b0;

        if (state != ST_RUN && i_tick) begin
            if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
                blink_n     = ~blink;
                blink_cnt_n = '0;
            end else if (blink_cnt != '1) begin
                blink_cnt_n = blink_cnt + 1'b1;
            end
        end

        case (state)
            ST_RUN: begin
                blink_n     = 1'b0;
                blink_cnt_n = '0;
                idle_n      = '0;
                hold_n      = '0;
                if (rise[BTN_C]) begin
                    state_n = ST_EDIT;
                    blink_n = 1'b1;
                end else if (eff_page != page_q) begin
                    page_n  = eff_page;
                    field_n = page_base;
                end else if (rise[BTN_L]) begin
                    field_n = (field_sel >= page_top) ? page_top : field_sel + 1'b1;
                end else if (rise[BTN_R]) begin
                    field_n = (field_sel <= page_base) ? page_base : field_sel - 1'b1;
                end
            end

            ST_EDIT: begin
                if (rise[BTN_C]) begin
                    go_run = 1'b1;
                end else if (rise[BTN_U] && !rise[BTN_D]) begin
                    inc_n   = 1'b1;
                    dir_n   = 1'b1;
                    hold_n  = '0;
                    idle_n  = '0;
                    state_n = ST_DELAY;
                end else if (rise[BTN_D] && !rise[BTN_U]) begin
                    dec_n   = 1'b1;
                    dir_n   = 1'b0;
                    hold_n  = '0;
                    idle_n  = '0;
                    state_n = ST_DELAY;
                end else begin
                    if (rise[BTN_L]) begin
                        field_n = (field_sel == SEL_W'(NUM_FIELDS - 1)) ? '0 : field_sel + 1'b1;
                    end else if (rise[BTN_R]) begin
                        field_n = (field_sel == '0) ? SEL_W'(NUM_FIELDS - 1) : field_sel - 1'b1;
                    end
                    if (|rise) begin
                        idle_n = '0;
                    end else if (i_tick) begin
                        if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) go_run = 1'b1;
                        else if (idle_cnt != '1) idle_n = idle_cnt + 1'b1;
                    end
                end
            end

            ST_DELAY, ST_REPEAT: begin
                idle_n = '0;
                if (!held) begin
                    state_n = ST_EDIT;
                    hold_n  = '0;
                end else if (i_tick) begin
                    if ((state == ST_DELAY  && hold_cnt == HOLD_W'(REPEAT_DELAY - 1)) ||
                        (state == ST_REPEAT && hold_cnt == HOLD_W'(REPEAT_RATE - 1))) begin
                        pulse   = 1'b1;
                        hold_n  = '0;
                        state_n = ST_REPEAT;
                    end else if (hold_cnt != '1) begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
                if (pulse) begin
                    inc_n = dir_up;
                    dec_n = ~dir_up;
                end
            end

            default: state_n = ST_RUN;
        endcase

        if (go_run) begin
            state_n     = ST_RUN;
            field_n     = page_base;
            page_n      = eff_page;
            blink_n     = 1'b0;
            blink_cnt_n = '0;
            idle_n      = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            field_sel <= SEL_W'(F_MSEC);
            page_q    <= '0;
            inc       <= 1'b0;
            dec       <= 1'b0;
            blink     <= 1'b0;
            dir_up    <= 1'b0;
            hold_cnt  <= '0;
            idle_cnt  <= '0;
            blink_cnt <= '0;
        end else begin
            state     <= state_n;
            field_sel <= field_n;
            page_q    <= page_n;
            inc       <= inc_n;
            dec       <= dec_n;
            blink     <= blink_n;
            dir_up    <= dir_n;
            hold_cnt  <= hold_n;
            idle_cnt  <= idle_n;
            blink_cnt <= blink_cnt_n;
        end
    end

    assign o_field_sel = field_sel;
    assign o_edit_mode = (state != ST_RUN);
    assign o_inc       = inc;
    assign o_dec       = dec;
    assign o_blink     = blink;

endmodule

// File: doc/watch_edit_cu.md
Name: watch_edit_cu

Overview:
- Next-generation control unit for the Basys3 watch/FND datapath; sits between debounced buttons and the time counters.
- Selects which of NUM_FIELDS time fields is displayed or edited, organised into pages chosen by a switch.
- Adds an explicit edit mode with single-cycle inc/dec pulses, hold-to-repeat, idle timeout back to run mode, and a blink output for the selected field.

Parameters:
- NUM_FIELDS, 4, total time fields (0 = least significant, e.g. msec).
- PAGE_SIZE, 2, fields per page; NUM_FIELDS must be a multiple of PAGE_SIZE.
- SEL_W, 2, width of the field index; must satisfy 2^SEL_W >= NUM_FIELDS.
- PAGE_W, 1, width of the page select input.
- REPEAT_DELAY, 500, i_tick count a button is held before auto-repeat starts.
- REPEAT_RATE, 100, i_tick count between auto-repeat pulses.
- IDLE_TIMEOUT, 10000, i_tick count with no button press in EDIT before returning to RUN.
- BLINK_HALF, 250, i_tick count per blink half-period.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_tick  in  1  one-cycle enable at 1 kHz; all timing counters advance only on it.
- i_btnL  in  1  debounced level; select the next more-significant field.
- i_btnR  in  1  debounced level; select the next less-significant field.
- i_btnU  in  1  debounced level; increment the selected field.
- i_btnD  in  1  debounced level; decrement the selected field.
- i_btnC  in  1  debounced level; toggle edit mode.
- i_page  in  PAGE_W  page select switch (generalises the time-mode switch).
- o_field_sel  out  SEL_W  index of the selected field.
- o_edit_mode  out  1  high in all edit states.
- o_inc  out  1  one-cycle increment pulse.
- o_dec  out  1  one-cycle decrement pulse.
- o_blink  out  1  blink enable for the selected digit.

Behaviour:
- Reset values: o_field_sel=0, o_edit_mode=0, o_inc=0, o_dec=0, o_blink=0, state RUN, all counters 0.
- Edge-detect registers reset to 1, so a button held through reset does not count as a press.
- A press is the rising edge of a button level: the level is high this cycle and the previous-cycle register is low.
- All outputs are registered. The response to a press sampled at edge k appears after edge k+1. o_inc and o_dec are exactly 1 cycle wide.
- Effective page: P = min(i_page, NUM_FIELDS/PAGE_SIZE - 1). Page base B = P*PAGE_SIZE.
- States: RUN, EDIT, DELAY, REPEAT.
- RUN:
  - A change of the effective page sets field_sel=B on the next cycle.
  - L press: field_sel+1, saturating at B+PAGE_SIZE-1. R press: field_sel-1, saturating at B.
  - U and D are ignored; o_inc and o_dec stay 0.
  - C press: go to EDIT. Clear the idle counter, set o_blink=1, clear the blink counter.
- EDIT:
  - L press: field_sel+1 modulo NUM_FIELDS (wraps, can cross pages). R press: field_sel-1 modulo NUM_FIELDS.
  - U press: o_inc=1, go to DELAY. D press: o_dec=1, go to DELAY. The held direction (U or D) is latched.
  - U and D pressed in the same cycle: both ignored, state unchanged.
  - C press: go to RUN, field_sel=B, o_blink=0.
  - Priority when several presses land in one cycle: C > U/D > L/R.
  - i_page changes are ignored while in edit states and take effect on return to RUN.
  - Any press clears the idle counter. When the idle counter reaches IDLE_TIMEOUT ticks, go to RUN exactly as for a C press.
- DELAY:
  - The hold counter counts ticks while the latched button stays high.
  - Release returns to EDIT with no further pulse.
  - Reaching REPEAT_DELAY: emit one pulse in the latched direction, clear the counter, go to REPEAT.
- REPEAT:
  - Emit one pulse every REPEAT_RATE ticks while the latched button is held. Release returns to EDIT.
- In DELAY and REPEAT, L, R, C and the opposite direction button are ignored, and the idle counter is held at 0.
- Blink: in edit states, o_blink toggles every BLINK_HALF ticks. In RUN, o_blink is forced to 0.
- Counter widths are $clog2 of the corresponding parameter + 1. Counters saturate rather than wrap.
- Asynchronous reset mid-operation aborts any state immediately to the reset values; no pulse is emitted.

Decomposition:
- Shared package watch_pkg holds:
  - state encoding (RUN=0, EDIT=1, DELAY=2, REPEAT=3),
  - field index constants (F_MSEC=0, F_SEC=1, F_MIN=2, F_HOUR=3),
  - the default timing constants.
- One sub-module: btn_edge, a parametrised-width vector rising-edge detector with prev registers reset to 1. It is instantiated once for {C,U,D,L,R}.

Test Plan:
Bench settings: tick every cycle, REPEAT_DELAY=5, REPEAT_RATE=2, IDLE_TIMEOUT=20, BLINK_HALF=3.
1. RUN, i_page=0: L press ×3 -> field_sel 1, 1, 1 (saturates). Set i_page=1 -> field_sel=2. R press -> stays 2. U press -> o_inc never high.
2. C press -> o_edit_mode=1 and o_blink=1 next cycle. o_blink toggles every 3 cycles. L press ×3 from field 2 -> 3, 0, 1 (wraps).
3. EDIT: U pulse for 1 cycle -> exactly one o_inc. Hold D for 12 cycles -> o_dec at press+1, then 5 ticks later, then every 2 ticks; 5 pulses total, none after release.
4. EDIT: U and D rise in the same cycle -> no pulse, state stays EDIT. C and L in the same cycle -> RUN, field_sel = page base.
5. EDIT, no presses for 20 ticks -> o_edit_mode falls, o_blink=0, field_sel = page base. Holding U in REPEAT for over 20 ticks -> no timeout.
6. Assert rst during REPEAT -> all outputs 0 asynchronously. Keep U held through reset release -> no o_inc until U is released and pressed again.
